// File: rtl/burst_memory_if.sv
// burst_memory_if: request/response bus between a burst master and burst_memory
interface burst_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [1:0] access_size;
    logic rw;
    logic enable;
    logic busy;
    logic [DATA_W-1:0] data_out;
    logic data_valid;
    logic error;
    modport master (
        output address, data_in, access_size, rw, enable,
        input busy, data_out, data_valid, error
    );
    modport slave (
        input address, data_in, access_size, rw, enable,
        output busy, data_out, data_valid, error
    );
endinterface

// File: rtl/burst_memory.sv
// burst_memory: byte-addressed big-endian burst memory; define MEM_ALIGN_CHECK_EN to reject misaligned requests
module burst_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 1048576
) (
    input logic clock,
    input logic reset,
    burst_memory_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WORDS = DEPTH / BYTES;
    localparam int WA_W = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [WORDS];
    logic [WA_W-1:0] word_addr;
    logic [3:0] beat, last;
    logic reject;
    logic unused_addr;
    // Bits above the storage range and below word alignment are deliberately dropped.
    assign unused_addr = ^bus.address;
`ifdef MEM_ALIGN_CHECK_EN
    assign reject = |bus.address[OFF_W-1:0];
    // One-cycle pulse for a misaligned request seen while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) bus.error <= 1'b0;
        else bus.error <= state == IDLE && bus.enable && reject;
    end
`else
    assign reject = 1'b0;
    assign bus.error = 1'b0;
`endif
    // Burst sequencer: accept while idle, then step one beat per cycle with wrapping word address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.data_out <= '0;
            word_addr <= '0;
            beat <= '0;
            last <= '0;
        end else begin
            bus.data_valid <= 1'b0;
            if (state == IDLE) begin
                if (bus.enable && !reject) begin
                    state <= bus.rw ? WRITE : READ;
                    bus.busy <= 1'b1;
                    word_addr <= bus.address[OFF_W +: WA_W];
                    beat <= '0;
                    last <= bus.access_size == 2'd0 ? 4'd0 :
                            bus.access_size == 2'd1 ? 4'd3 :
                            bus.access_size == 2'd2 ? 4'd7 : 4'd15;
                end
            end else begin
                if (state == READ) begin
                    bus.data_out <= mem[word_addr];
                    bus.data_valid <= 1'b1;
                end
                word_addr <= word_addr + 1'b1;
                beat <= beat + 1'b1;
                if (beat == last) begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
            end
        end
    end
    // Storage is never reset; a write beat lands on every WRITE-state edge.
    always_ff @(posedge clock) begin
        if (state == WRITE) mem[word_addr] <= bus.data_in;
    end
endmodule
